// File: rtl/sync_ram_hs.sv
// Single-port synchronous RAM with split data buses, self-clearing init after reset,
// a configurable read-latency pipeline, and registered read-valid/error pulses.
module sync_ram_hs #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 2**AWIDTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              rd_valid,
  output logic              err
);

  localparam int PW = AWIDTH + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  if (RD_LAT < 1 || RD_LAT > 4 || DEPTH < 1 || DEPTH > 2**AWIDTH) begin : g_param_check
    $error("sync_ram_hs: illegal parameter combination");
  end

  logic [0:0]        state_q, state_d;
  logic [PW-1:0]     clear_ptr_q, clear_ptr_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [DWIDTH-1:0] pd_q [RD_LAT];
  logic [DWIDTH-1:0] pd_d [RD_LAT];

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  logic              idle;
  logic              in_range;
  logic              rd_issue;
  logic [DWIDTH-1:0] rd_word;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    in_range = ({1'b0, addr} < PW'(DEPTH));
    rd_issue = idle && rd && !wr;
    rd_word  = '0;
    if (in_range) begin
      rd_word = mem[addr];
    end

    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = wdata;

    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q[AWIDTH-1:0];
        mem_wdata   = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == PW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        case ({wr, rd})
          2'b10: begin
            if (in_range) begin
              mem_we = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          2'b01:   err_d = !in_range;
          2'b11:   err_d = 1'b1;
          default: err_d = 1'b0;
        endcase
      end
    endcase

    // Valid bits shift every cycle; data stages only advance behind a valid bit,
    // so the last stage (rdata) changes exclusively together with rd_valid.
    pv_d     = RD_LAT'({pv_q, rd_issue});
    pd_d     = pd_q;
    if (rd_issue) begin
      pd_d[0] = rd_word;
    end
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      if (pv_q[i-1]) begin
        pd_d[i] = pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clear_ptr_q <= '0;
      err_q       <= 1'b0;
      pv_q        <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      err_q       <= err_d;
      pv_q        <= pv_d;
      pd_q        <= pd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ready    = idle;
  assign rdata    = pd_q[RD_LAT-1];
  assign rd_valid = pv_q[RD_LAT-1];
  assign err      = err_q;

endmodule

// File: tb/tb_sync_ram_hs.sv
// Directed bench for sync_ram_hs: three instances (32/lat1, 20/lat3, 32/lat2) exercised
// with a vector table plus hand-written multi-cycle sequences.
module tb_sync_ram_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [3];
  logic       wr       [3];
  logic       rd       [3];
  logic [4:0] addr     [3];
  logic [7:0] wdata    [3];
  logic       ready    [3];
  logic [7:0] rdata    [3];
  logic       rd_valid [3];
  logic       err      [3];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sync_ram_hs #(
      .AWIDTH(5),
      .DWIDTH(8),
      .DEPTH (g == 1 ? 20 : 32),
      .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .wr      (wr[g]),
      .rd      (rd[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .ready   (ready[g]),
      .rdata   (rdata[g]),
      .rd_valid(rd_valid[g]),
      .err     (err[g])
    );
  end

  typedef struct {
    logic       w;
    logic       r;
    logic [4:0] a;
    logic [7:0] d;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_rdata;
    logic       e_err;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cmd(input int k, input logic w, input logic r, input logic [4:0] a,
                     input logic [7:0] d);
    wr[k]    = w;
    rd[k]    = r;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // Reads every word in consecutive cycles and expects a stream of zeros at the given latency.
  task automatic readback_zero(input int k, input int depth, input int lat);
    logic exp_v;
    for (int i = 0; i < depth + lat; i++) begin
      if (i < depth) cmd(k, 1'b0, 1'b1, 5'(i), 8'h00);
      else           cmd(k, 1'b0, 1'b0, 5'd0, 8'h00);
      step();
      exp_v = (i >= lat - 1) && (i < depth + lat - 1);
      chk($sformatf("zero[%0d].valid@%0d", k, i), 32'(rd_valid[k]), 32'(exp_v));
      chk($sformatf("zero[%0d].err@%0d", k, i), 32'(err[k]), 32'd0);
      if (exp_v) chk($sformatf("zero[%0d].rdata@%0d", k, i), 32'(rdata[k]), 32'd0);
    end
  endtask

  task automatic read_expect(input int k, input logic [4:0] a, input int lat,
                             input logic [7:0] exp_d, input logic exp_e);
    cmd(k, 1'b0, 1'b1, a, 8'h00);
    for (int j = 1; j <= lat; j++) begin
      step();
      cmd(k, 1'b0, 1'b0, 5'd0, 8'h00);
      if (j == 1) chk($sformatf("rd[%0d] a=%0d err", k, a), 32'(err[k]), 32'(exp_e));
      chk($sformatf("rd[%0d] a=%0d valid@%0d", k, a, j), 32'(rd_valid[k]), 32'(j == lat));
      if (j == lat) chk($sformatf("rd[%0d] a=%0d rdata", k, a), 32'(rdata[k]), 32'(exp_d));
    end
    step();
    chk($sformatf("rd[%0d] a=%0d valid after", k, a), 32'(rd_valid[k]), 32'd0);
    chk($sformatf("rd[%0d] a=%0d err after", k, a), 32'(err[k]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise [3];
    logic [7:0] exp_rd;
    logic       ev;

    vt[0]  = '{1'b0, 1'b1, 5'd0,  8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 5'd31, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 5'd5,  8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 5'd5,  8'h00, 1'b1, 1'b1, 8'hA5, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 5'd7,  8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 5'd7,  8'hFF, 1'b1, 1'b0, 8'hA5, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 5'd7,  8'h00, 1'b1, 1'b1, 8'h3C, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 5'd31, 8'h5A, 1'b1, 1'b0, 8'h3C, 1'b0};
    vt[10] = '{1'b0, 1'b1, 5'd31, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0};
    vt[11] = '{1'b0, 1'b1, 5'd5,  8'h00, 1'b1, 1'b1, 8'hA5, 1'b0};
    vt[12] = '{1'b1, 1'b0, 5'd0,  8'hFF, 1'b1, 1'b0, 8'hA5, 1'b0};
    vt[13] = '{1'b0, 1'b1, 5'd0,  8'h00, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[14] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 8'hFF, 1'b0};
    vt[15] = '{1'b1, 1'b0, 5'd5,  8'h11, 1'b1, 1'b0, 8'hFF, 1'b0};
    vt[16] = '{1'b0, 1'b1, 5'd5,  8'h00, 1'b1, 1'b1, 8'h11, 1'b0};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      cmd(k, 1'b0, 1'b0, 5'd0, 8'h00);
      rise[k] = 0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset[%0d].ready", k), 32'(ready[k]), 32'd0);
      chk($sformatf("reset[%0d].rdata", k), 32'(rdata[k]), 32'd0);
      chk($sformatf("reset[%0d].valid", k), 32'(rd_valid[k]), 32'd0);
      chk($sformatf("reset[%0d].err", k), 32'(err[k]), 32'd0);
      rst[k] = 1'b0;
    end
    // Commands during the clear must be ignored without raising err.
    cmd(0, 1'b1, 1'b1, 5'd9, 8'hEE);
    cmd(1, 1'b1, 1'b0, 5'd2, 8'h77);

    for (int c = 1; c <= 40; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        if (rise[k] == 0) begin
          chk($sformatf("init[%0d].err@%0d", k, c), 32'(err[k]), 32'd0);
          chk($sformatf("init[%0d].valid@%0d", k, c), 32'(rd_valid[k]), 32'd0);
          if (ready[k] === 1'b1) begin
            rise[k] = c;
            cmd(k, 1'b0, 1'b0, 5'd0, 8'h00);
          end
        end
      end
      if (rise[0] != 0 && rise[1] != 0 && rise[2] != 0) break;
    end
    chk("init[0].ready_cycles", 32'(rise[0]), 32'd32);
    chk("init[1].ready_cycles", 32'(rise[1]), 32'd20);
    chk("init[2].ready_cycles", 32'(rise[2]), 32'd32);

    readback_zero(0, 32, 1);
    readback_zero(1, 20, 3);
    readback_zero(2, 32, 2);

    for (int i = 0; i < 17; i++) begin
      cmd(0, vt[i].w, vt[i].r, vt[i].a, vt[i].d);
      step();
      chk($sformatf("vec[%0d].ready", i), 32'(ready[0]), 32'(vt[i].e_ready));
      chk($sformatf("vec[%0d].valid", i), 32'(rd_valid[0]), 32'(vt[i].e_valid));
      chk($sformatf("vec[%0d].rdata", i), 32'(rdata[0]), 32'(vt[i].e_rdata));
      chk($sformatf("vec[%0d].err", i), 32'(err[0]), 32'(vt[i].e_err));
    end
    cmd(0, 1'b0, 1'b0, 5'd0, 8'h00);

    for (int i = 0; i < 4; i++) begin
      cmd(1, 1'b1, 1'b0, 5'(i), 8'(i + 1));
      step();
      chk($sformatf("pipe.wr%0d.err", i), 32'(err[1]), 32'd0);
      chk($sformatf("pipe.wr%0d.valid", i), 32'(rd_valid[1]), 32'd0);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 4) cmd(1, 1'b0, 1'b1, 5'(i), 8'h00);
      else       cmd(1, 1'b0, 1'b0, 5'd0, 8'h00);
      step();
      ev     = (i >= 2) && (i <= 5);
      exp_rd = (i < 2) ? 8'h00 : ((i <= 5) ? 8'(i - 1) : 8'h04);
      chk($sformatf("pipe.rd@%0d.valid", i), 32'(rd_valid[1]), 32'(ev));
      chk($sformatf("pipe.rd@%0d.rdata", i), 32'(rdata[1]), 32'(exp_rd));
    end

    cmd(1, 1'b1, 1'b0, 5'd25, 8'h77);
    step();
    chk("oor.wr25.err", 32'(err[1]), 32'd1);
    cmd(1, 1'b0, 1'b0, 5'd0, 8'h00);
    step();
    chk("oor.wr25.err_clear", 32'(err[1]), 32'd0);
    chk("oor.hold_rdata", 32'(rdata[1]), 32'h04);
    read_expect(1, 5'd25, 3, 8'h00, 1'b1);
    read_expect(1, 5'd5, 3, 8'h00, 1'b0);
    cmd(1, 1'b1, 1'b0, 5'd19, 8'h99);
    step();
    chk("oor.wr19.err", 32'(err[1]), 32'd0);
    cmd(1, 1'b1, 1'b0, 5'd20, 8'h66);
    step();
    chk("oor.wr20.err", 32'(err[1]), 32'd1);
    read_expect(1, 5'd19, 3, 8'h99, 1'b0);
    read_expect(1, 5'd20, 3, 8'h00, 1'b1);

    cmd(2, 1'b1, 1'b0, 5'd3, 8'h42);
    step();
    read_expect(2, 5'd3, 2, 8'h42, 1'b0);
    cmd(2, 1'b0, 1'b1, 5'd3, 8'h00);
    step();
    cmd(2, 1'b0, 1'b0, 5'd0, 8'h00);
    rst[2] = 1'b1;
    step();
    chk("midrst.valid", 32'(rd_valid[2]), 32'd0);
    chk("midrst.rdata", 32'(rdata[2]), 32'd0);
    chk("midrst.ready", 32'(ready[2]), 32'd0);
    rst[2]  = 1'b0;
    rise[2] = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk($sformatf("midrst.valid@%0d", c), 32'(rd_valid[2]), 32'd0);
      if (ready[2] === 1'b1) begin
        rise[2] = c;
        break;
      end
    end
    chk("midrst.ready_cycles", 32'(rise[2]), 32'd32);
    readback_zero(2, 32, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
